keypad_scan_fifo: RTL and testbench

Parametrised keypad front end for the signed calculator. It scans an R×C active-low matrix keypad and synchronises and debounces the row inputs. Each debounced press is converted to a linear key code and queued in a show-ahead FIFO, which downstream control drains with a KeyRdy/KeyRd handshake. It replaces the fixed 4×4 single-key input stage: geometry and debounce are generic, presses are buffered, ghost presses are rejected, and overflow is flagged.

---
 rtl/keypad_scan_fifo.sv | 182 ++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_fifo.sv
// Scans an active-low ROWS x COLS keypad, debounces single presses and queues
// their linear codes (row*COLS + col) in a show-ahead FIFO with sticky overflow.
module keypad_scan_fifo #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int FIFO_DEPTH      = 4,
    localparam int CW             = $clog2(ROWS * COLS),
    localparam int CNTW           = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [ROWS-1:0] RowIn,
    output logic [COLS-1:0] ColOut,
    output logic            KeyRdy,
    input  logic            KeyRd,
    output logic [CW-1:0]   KeyCode,
    output logic [CNTW-1:0] KeyCount,
    output logic            Overflow
);

    localparam int ROWW = $clog2(ROWS);
    localparam int COLW = $clog2(COLS);
    localparam int DWW  = $clog2(SCAN_DWELL);
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PTRW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t          state_q, state_d;
    logic [ROWS-1:0] row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [COLW-1:0] col_q, col_d, col_next;
    logic [ROWW-1:0] row_q, row_d, low_row;
    logic [DWW-1:0]  dwell_q, dwell_d;
    logic [DBW-1:0]  deb_q, deb_d, deb_inc;
    logic [ROWS-1:0] rs, rs_inv, held_pat;
    logic            single_low, push;

    logic [CW-1:0]   mem_q [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            pop, full, push_ok;
    logic [CW-1:0]   push_code;

    assign rs = row_s2_q;

    // NOTE: every variable driven here gets a default first, otherwise the
    // paths that skip an assignment would infer latches.
    always_comb begin
        row_s1_d = RowIn;
        row_s2_d = row_s1_q;

        rs_inv     = ~rs;
        single_low = (rs_inv != '0) && ((rs_inv & (rs_inv - 1'b1)) == '0);
        low_row    = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!rs[r]) low_row = ROWW'(r);
        end

        held_pat        = '1;
        held_pat[row_q] = 1'b0;
        col_next        = (col_q == COLW'(COLS - 1)) ? '0 : col_q + 1'b1;
        deb_inc         = deb_q + 1'b1;

        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        deb_d   = deb_q;
        push    = 1'b0;

        case (state_q)
            SCAN: begin
                if (dwell_q == DWW'(SCAN_DWELL - 1)) begin
                    dwell_d = '0;
                    if (single_low) begin
                        row_d   = low_row;
                        deb_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs == held_pat) begin
                    if (deb_inc == DBW'(DEBOUNCE_CYCLES)) begin
                        push    = 1'b1;
                        deb_d   = '0;
                        state_d = HELD;
                    end else begin
                        deb_d = deb_inc;
                    end
                end else begin
                    state_d = SCAN;
                    col_d   = col_next;
                end
            end
            HELD: begin
                // Release is only accepted after a full run of all-high samples.
                if (&rs) begin
                    if (deb_inc == DBW'(DEBOUNCE_CYCLES)) begin
                        deb_d   = '0;
                        state_d = SCAN;
                        col_d   = col_next;
                    end else begin
                        deb_d = deb_inc;
                    end
                end else begin
                    deb_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        push_code = CW'(int'(row_q) * COLS + int'(col_q));
        pop       = KeyRd && (count_q != '0);
        full      = (count_q == CNTW'(FIFO_DEPTH));
        push_ok   = push && (!full || pop);
        wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ovf_d     = ovf_q | (push & full & !pop);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= SCAN;
            row_s1_q <= '1;
            row_s2_q <= '1;
            col_q    <= '0;
            row_q    <= '0;
            dwell_q  <= '0;
            deb_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_s1_q <= row_s1_d;
            row_s2_q <= row_s2_d;
            col_q    <= col_d;
            row_q    <= row_d;
            dwell_q  <= dwell_d;
            deb_q    <= deb_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; stale entries are
    // never visible because KeyCode is gated by the occupancy count.
    always_ff @(posedge Clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_code;
    end

    always_comb begin
        ColOut        = '1;
        ColOut[col_q] = 1'b0;
    end

    assign KeyRdy   = (count_q != '0);
    assign KeyCode  = KeyRdy ? mem_q[rd_ptr_q] : '0;
    assign KeyCount = count_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: a keypad model drives rows from the
// column strobe and a code queue holds the codes expected from the FIFO.
module tb_keypad_scan_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_rdy;
    logic       key_rd;
    logic [3:0] key_code;
    logic [2:0] key_count;
    logic       overflow;

    logic [15:0]  keys;
    int unsigned  exp_q[$];
    logic         exp_ovf;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    keypad_scan_fifo dut (
        .Clock   (clk),
        .Reset   (rst_n),
        .RowIn   (row_in),
        .ColOut  (col_out),
        .KeyRdy  (key_rdy),
        .KeyRd   (key_rd),
        .KeyCode (key_code),
        .KeyCount(key_count),
        .Overflow(overflow)
    );

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_expect(input int r, input int c);
        keys[r*4+c] = 1'b1;
        if (exp_q.size() < 4) exp_q.push_back(r * 4 + c);
        else exp_ovf = 1'b1;
    endtask

    task automatic wait_rdy(input int limit, output int lat);
        lat = 0;
        while (!key_rdy && lat < limit) begin
            @(negedge clk);
            lat++;
        end
        check("rdy_timeout", key_rdy, 1);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check({tag, "_rdy"}, key_rdy, 1);
        check(tag, key_code, exp);
        key_rd = 1'b1;
        @(negedge clk);
        key_rd = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_colout"}, col_out, 4'b1110);
        check({tag, "_rdy"}, key_rdy, 0);
        check({tag, "_count"}, key_count, 0);
        check({tag, "_code"}, key_code, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        int lat;
        int cons;
        logic [3:0] prev_col;
        logic [3:0] col_seq [4];

        rst_n   = 1'b0;
        keys    = '0;
        key_rd  = 1'b0;
        exp_ovf = 1'b0;

        // Reset and free-running column scan
        cycles(2);
        rst_n = 1'b1;
        check_reset_outputs("reset");
        col_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        for (int i = 0; i < 4; i++) begin
            cycles(2);
            check("colout_hold", col_out, (i == 0) ? 4'b1110 : col_seq[i-1]);
            cycles(2);
            check("colout_step", col_out, col_seq[i]);
        end

        // Single press of (1,2), held for 100 cycles
        press_expect(1, 2);
        wait_rdy(40, lat);
        check("press_latency_ok", (lat <= 27), 1);
        check("single_count", key_count, 1);
        cycles(100 - lat);
        check("no_autorepeat", key_count, 1);
        keys = '0;
        cycles(20);
        pop_check("single_code");
        check("single_pop_rdy", key_rdy, 0);
        check("single_pop_count", key_count, 0);

        // Bouncing key (0,0) never settles long enough
        for (int i = 0; i < 13; i++) begin
            keys[0] = ~keys[0];
            cycles(3);
        end
        keys = '0;
        cycles(20);
        check("bounce_rdy", key_rdy, 0);
        check("bounce_count", key_count, 0);

        // Five presses into a four-entry FIFO
        for (int k = 0; k < 5; k++) begin
            int code;
            code = (k == 4) ? 3 : k * 5;
            press_expect(code / 4, code % 4);
            cycles(40);
            keys = '0;
            cycles(20);
        end
        check("ovf_count", key_count, exp_q.size());
        check("ovf_flag", overflow, exp_ovf);
        pop_check("order_0");
        pop_check("order_1");
        pop_check("order_2");
        pop_check("order_3");
        key_rd = 1'b1;
        @(negedge clk);
        key_rd = 1'b0;
        check("empty_pop_rdy", key_rdy, 0);
        check("empty_pop_count", key_count, 0);
        check("empty_pop_code", key_code, 0);
        check("ovf_sticky", overflow, 1);

        // Ghost pair in column 1 is rejected and scanning keeps moving
        keys[1] = 1'b1;
        keys[9] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            prev_col = col_out;
            cycles(4);
            check("ghost_scan_moves", (col_out != prev_col), 1);
        end
        check("ghost_rdy", key_rdy, 0);
        keys = '0;
        cycles(20);

        // Reset in the middle of debouncing (3,3)
        keys[15] = 1'b1;
        cons = 0;
        for (int i = 0; i < 80 && cons < 6; i++) begin
            @(negedge clk);
            cons = (col_out == 4'b0111) ? cons + 1 : 0;
        end
        check("debounce_reached", cons, 6);
        check("debounce_no_push", key_rdy, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        cycles(2);
        rst_n = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        check_reset_outputs("after_reset");
        if (exp_q.size() < 4) exp_q.push_back(15);
        wait_rdy(40, lat);
        check("rescan_latency_ok", (lat <= 27), 1);
        cycles(40);
        check("rescan_once", key_count, exp_q.size());
        check("rescan_code", key_code, exp_q[0]);
        keys = '0;
        cycles(20);
        press_expect(2, 1);
        cycles(40);
        keys = '0;
        cycles(20);
        check("two_entries", key_count, exp_q.size());
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("flush_count", key_count, exp_q.size());
        check("flush_rdy", key_rdy, 0);
        check("flush_code", key_code, 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
